// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and helpers for the KLP32V1 run/step controller.
// Provides the controller state encoding and the divider width helper.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } run_state_t;

    // Bits needed to count 0..(clk_hz/step_hz)-1.
    function automatic int div_width(int clk_hz, int step_hz);
        return $clog2(clk_hz / step_hz);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_debounce.sv
// Button synchroniser and debouncer with a rising-edge event output.
// Ports: clk, reset (sync, active-high), i_btn (raw), o_level (accepted
// level), o_rise (one-cycle pulse on an accepted 0->1 transition).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          settle;

    assign differ = (sync != o_level);
    // The level is taken once it has differed for DEBOUNCE_CYCLES samples.
    assign settle = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            sync    <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            s1     <= i_btn;
            sync   <= s1;
            o_rise <= settle && sync;
            if (settle) begin
                o_level <= sync;
                cnt     <= '0;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer producing the core instruction enable.
// Ports: clk, reset, i_run_sw, i_step_btn, i_bp_en, i_bp_addr, i_pcOut in;
// o_cpu_ce, o_state, o_halted, o_inst_count out (all registered).
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int STEP_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run_sw,
    input  logic        i_step_btn,
    input  logic        i_bp_en,
    input  logic [31:0] i_bp_addr,
    input  logic [31:0] i_pcOut,
    output logic        o_cpu_ce,
    output logic [1:0]  o_state,
    output logic        o_halted,
    output logic [31:0] o_inst_count
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int DW  = div_width(CLK_HZ, STEP_HZ);

    run_state_t    state_q;
    run_state_t    state_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          ce_q;
    logic          ce_d;
    logic          skip_q;
    logic          skip_d;
    logic          halted_q;
    logic          run_prev;
    logic [31:0]   count_q;
    logic          step_evt;
    logic          step_level;
    logic          tick;
    logic          bp_hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (i_step_btn),
        .o_level(step_level),
        .o_rise (step_evt)
    );

    assign tick   = (state_q == RUN) && (div_q == DW'(DIV - 1));
    // skip_bp lets a run that starts on the breakpoint PC retire it once.
    assign bp_hit = i_bp_en && (i_pcOut == i_bp_addr) && !skip_q;

    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        skip_d  = skip_q;
        div_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (i_run_sw) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (step_evt) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (!i_run_sw) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_d = BREAK;
                    end else begin
                        ce_d   = 1'b1;
                        skip_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STEP: begin
                ce_d    = 1'b1;
                state_d = IDLE;
            end
            BREAK: begin
                if (step_evt) begin
                    state_d = STEP;
                end else if (run_prev && !i_run_sw) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            ce_q     <= 1'b0;
            skip_q   <= 1'b0;
            halted_q <= 1'b1;
            run_prev <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            skip_q   <= skip_d;
            halted_q <= (state_d == IDLE) || (state_d == BREAK);
            run_prev <= i_run_sw;
            if (ce_q) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign o_cpu_ce     = ce_q;
    assign o_state      = state_q;
    assign o_halted     = halted_q;
    assign o_inst_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with CLK_HZ=10, STEP_HZ=1, DEBOUNCE=4.
// Table-driven run/step vectors followed by breakpoint and reset sequences.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] inst_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        run;
        logic        btn;
        int          n;
        logic [1:0]  st;
        logic        ce;
        logic        hl;
        logic [31:0] cnt;
    } vec_t;

    vec_t v[17];

    cpu_run_ctrl #(
        .CLK_HZ(10),
        .STEP_HZ(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run_sw    (run_sw),
        .i_step_btn  (step_btn),
        .i_bp_en     (bp_en),
        .i_bp_addr   (bp_addr),
        .i_pcOut     (pc),
        .o_cpu_ce    (cpu_ce),
        .o_state     (state),
        .o_halted    (halted),
        .o_inst_count(inst_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; the modelled core advances its PC after each ce pulse.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (cpu_ce) pc = pc + 32'd4;
    endtask

    initial begin
        int pulses;
        logic [1:0] st_at;
        logic seen;

        v[0]  = '{1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 32'd0};
        v[1]  = '{1'b1, 1'b0, 9, 2'd1, 1'b0, 1'b0, 32'd0};
        v[2]  = '{1'b1, 1'b0, 1, 2'd1, 1'b1, 1'b0, 32'd0};
        v[3]  = '{1'b1, 1'b0, 1, 2'd1, 1'b0, 1'b0, 32'd1};
        v[4]  = '{1'b1, 1'b0, 9, 2'd1, 1'b1, 1'b0, 32'd1};
        v[5]  = '{1'b1, 1'b0, 10, 2'd1, 1'b1, 1'b0, 32'd2};
        v[6]  = '{1'b1, 1'b0, 5, 2'd1, 1'b0, 1'b0, 32'd3};
        v[7]  = '{1'b0, 1'b0, 1, 2'd0, 1'b0, 1'b1, 32'd3};
        v[8]  = '{1'b0, 1'b1, 1, 2'd0, 1'b0, 1'b1, 32'd3};
        v[9]  = '{1'b0, 1'b0, 3, 2'd0, 1'b0, 1'b1, 32'd3};
        v[10] = '{1'b0, 1'b1, 3, 2'd0, 1'b0, 1'b1, 32'd3};
        v[11] = '{1'b0, 1'b0, 6, 2'd0, 1'b0, 1'b1, 32'd3};
        v[12] = '{1'b0, 1'b1, 6, 2'd0, 1'b0, 1'b1, 32'd3};
        v[13] = '{1'b0, 1'b0, 1, 2'd2, 1'b0, 1'b0, 32'd3};
        v[14] = '{1'b0, 1'b0, 1, 2'd0, 1'b1, 1'b1, 32'd3};
        v[15] = '{1'b0, 1'b0, 1, 2'd0, 1'b0, 1'b1, 32'd4};
        v[16] = '{1'b0, 1'b0, 8, 2'd0, 1'b0, 1'b1, 32'd4};

        repeat (2) cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ce", 32'(cpu_ce), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_count", inst_count, 32'd0);
        reset = 1'b0;

        // Run pulses at 10/20/30 cycles, then glitchy step presses.
        for (int i = 0; i < 17; i++) begin
            run_sw   = v[i].run;
            step_btn = v[i].btn;
            repeat (v[i].n) cyc();
            chk($sformatf("v%0d_state", i), 32'(state), 32'(v[i].st));
            chk($sformatf("v%0d_ce", i), 32'(cpu_ce), 32'(v[i].ce));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v[i].hl));
            chk($sformatf("v%0d_count", i), inst_count, v[i].cnt);
        end

        // Breakpoint at 0x0C reached after three retired instructions.
        bp_en   = 1'b1;
        bp_addr = 32'h0C;
        pc      = 32'h0;
        run_sw  = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (cpu_ce) pulses++;
            if (state == 2'd3) break;
        end
        chk("bp_pulses", 32'(pulses), 32'd3);
        chk("bp_state", 32'(state), 32'd3);
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_pc", pc, 32'h0C);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (cpu_ce) pulses++;
        end
        chk("bp_hold_pulses", 32'(pulses), 32'd0);
        chk("bp_hold_state", 32'(state), 32'd3);
        chk("bp_hold_count", inst_count, 32'd7);

        // Step out of BREAK; run_sw is still high so RUN follows.
        step_btn = 1'b1;
        pulses   = 0;
        st_at    = 2'd3;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) step_btn = 1'b0;
            cyc();
            if (cpu_ce) begin
                pulses++;
                st_at = state;
            end
        end
        chk("brk_step_pulses", 32'(pulses), 32'd1);
        chk("brk_step_then_idle", 32'(st_at), 32'd0);
        chk("brk_step_rerun", 32'(state), 32'd1);
        run_sw = 1'b0;
        cyc();
        chk("runoff_idle", 32'(state), 32'd0);

        // Restart on the breakpoint PC: first tick retires it.
        pc     = 32'h0C;
        run_sw = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (cpu_ce) pulses++;
        end
        chk("skip_pulses", 32'(pulses), 32'd1);
        chk("skip_state", 32'(state), 32'd1);
        pc     = 32'h0C;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (cpu_ce) pulses++;
            if (state == 2'd3) break;
        end
        chk("rebreak_pulses", 32'(pulses), 32'd0);
        chk("rebreak_state", 32'(state), 32'd3);
        chk("rebreak_count", inst_count, 32'd9);

        // Falling run_sw leaves BREAK; reset lands 3 cycles before a tick.
        run_sw = 1'b0;
        cyc();
        chk("brk_fall_idle", 32'(state), 32'd0);
        bp_en  = 1'b0;
        run_sw = 1'b1;
        cyc();
        chk("rerun_state", 32'(state), 32'd1);
        repeat (6) cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_count", inst_count, 32'd0);
        chk("midrst_ce", 32'(cpu_ce), 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (cpu_ce) pulses++;
        end
        chk("midrst_no_old_tick", 32'(pulses), 32'd0);

        // Count wrap, then run_sw drop on the tick cycle.
        force dut.count_q = 32'hFFFF_FFFF;
        cyc();
        release dut.count_q;
        chk("preload_count", inst_count, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (cpu_ce) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wrap_pulse_seen", 32'(seen), 32'd1);
        cyc();
        chk("wrap_count", inst_count, 32'd0);
        repeat (8) cyc();
        run_sw = 1'b0;
        cyc();
        chk("drop_tick_ce", 32'(cpu_ce), 32'd0);
        chk("drop_tick_state", 32'(state), 32'd0);
        chk("drop_tick_halted", 32'(halted), 32'd1);
        chk("drop_tick_count", inst_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/breakpoint controller that sequences the KLP32V1 single-cycle core on the DE10-Lite. The core is clocked by the board clock and is gated by o_cpu_ce, a single-cycle enable pulse; each pulse retires exactly one instruction. This block produces that pulse at a divided rate in RUN mode, or once per debounced button press in step mode. It halts on a PC breakpoint and exposes a retired-instruction count for the display logic.

Parameters:
CLK_HZ, 50_000_000, board clock frequency.
STEP_HZ, 1, instruction rate in RUN mode; divider terminal count DIV = CLK_HZ/STEP_HZ (must be >= 2).
DEBOUNCE_CYCLES, 1_000_000, number of stable cycles required before a button level is accepted.

Ports:
clk  in  1  board clock
reset  in  1  synchronous, active-high
i_run_sw  in  1  run switch; level, already synchronised
i_step_btn  in  1  step button, active-high, raw and bouncy; synchronise with 2 flops internally
i_bp_en  in  1  breakpoint enable
i_bp_addr  in  32  breakpoint PC
i_pcOut  in  32  current core PC
o_cpu_ce  out  1  one-cycle instruction enable
o_state  out  2  0=IDLE 1=RUN 2=STEP 3=BREAK
o_halted  out  1  high in IDLE or BREAK
o_inst_count  out  32  instructions retired, i.e. number of o_cpu_ce pulses

Behaviour:
- Reset (synchronous; highest priority; applies at any time, including mid-RUN):
  - state=IDLE, o_cpu_ce=0, o_inst_count=0, divider=0, debounce counter=0, accepted button level=0, skip_bp=0.
- Debouncer:
  - Synchronised button differs from the accepted level -> counter increments; any match resets the counter to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level updates.
  - step_evt is a 1-cycle pulse on an accepted 0->1 transition only.
- Divider:
  - Counts 0..DIV-1 only while in RUN; held at 0 in every other state.
  - tick = (divider==DIV-1) while in RUN.
- FSM transitions:
  - IDLE: i_run_sw=1 -> RUN. Otherwise step_evt -> STEP.
  - RUN: i_run_sw=0 -> IDLE; this takes priority over a same-cycle tick, so no pulse is issued.
  - RUN on tick:
    - If i_bp_en && i_pcOut==i_bp_addr && !skip_bp -> BREAK, no pulse.
    - Otherwise o_cpu_ce=1 for that cycle and skip_bp clears.
  - STEP: o_cpu_ce=1 for exactly one cycle, then -> IDLE. Breakpoints are ignored in STEP.
  - BREAK:
    - step_evt -> STEP.
    - i_run_sw falling edge (registered previous value) -> IDLE.
    - i_run_sw stays high -> remain in BREAK; no auto-resume.
  - IDLE -> RUN sets skip_bp=1, so a run starting at the breakpoint PC executes that instruction first.
- Step button in RUN is ignored; step_evt is dropped, not queued.
- o_cpu_ce is registered: high during the cycle after the decision; never high in two consecutive cycles in RUN (guaranteed by DIV>=2).
- o_inst_count increments on each cycle o_cpu_ce=1 and wraps 0xFFFFFFFF -> 0.
- o_state and o_halted are registered and reflect the current state.
- i_pcOut is sampled only on tick; the core PC is stable because it changes only after a ce pulse.

Decomposition:
- Package cpu_ctrl_pkg:
  - typedef enum logic[1:0] run_state_t {IDLE, RUN, STEP, BREAK}.
  - Function computing the divider width as $clog2(CLK_HZ/STEP_HZ).
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, i_btn, o_level, o_rise) holds the synchroniser and debouncer; the board's reset button uses it too.

Test Plan:
Use CLK_HZ=10, STEP_HZ=1, DEBOUNCE_CYCLES=4 throughout.
1. Reset, then run_sw=1 for 35 cycles -> pulses at cycles 10, 20, 30 after entering RUN; o_inst_count=3; o_halted=0.
2. From IDLE, step_btn high for 6 cycles with 1-cycle glitches beforehand -> exactly one o_cpu_ce pulse; state returns to 0 (IDLE); glitches shorter than 4 cycles produce nothing.
3. bp_en=1, bp_addr=0x0C, pcOut advancing 0,4,8,0x0C per pulse in RUN -> 3 pulses, then state=3 (BREAK) and o_halted=1; no further pulses with run_sw held high.
4. In BREAK, a step press -> one pulse, then IDLE. Toggling run_sw 0->1 with pcOut=0x0C -> the first tick pulses (skip_bp); a later return to 0x0C breaks again.
5. Assert reset while in RUN, 3 cycles before a tick -> next cycle state=IDLE, count=0, no pulse at the old tick time.
6. Preload count to 0xFFFFFFFF via the run sequence with forced initial value -> the next pulse wraps it to 0; run_sw drop coinciding with tick -> no pulse, state=IDLE.
